// File: rtl/icache_meta_array.sv
// icache_meta_array: N-way tag/valid store with tree PLRU replacement and a sequenced flash invalidate.
module icache_meta_array #(
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_way    = $clog2(num_ways),
  parameter int tagwidth = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_index-1:0]  index,
  input  logic [tagwidth-1:0] lookup_tag,
  output logic                hit,
  output logic [s_way-1:0]    hit_way,
  output logic [s_way-1:0]    victim_way,
  input  logic                touch,
  input  logic                fill,
  input  logic [s_way-1:0]    fill_way,
  input  logic [tagwidth-1:0] fill_tag,
  input  logic                inval_req,
  output logic                busy
);
  localparam int num_set = 2**s_index;
  localparam int np = num_ways - 1;
  typedef enum logic {IDLE, INVAL} state_t;
  state_t state;
  logic [s_index-1:0] ctr;
  logic [tagwidth-1:0] tags [num_set][num_ways];
  logic [num_ways-1:0] valid [num_set];
  logic [num_ways-2:0] plru [num_set];
  logic match;
  // Walk leaf-to-root; a left child (odd node number) makes its parent point right.
  function automatic logic [num_ways-2:0] access(input logic [num_ways-2:0] p, input logic [s_way-1:0] w);
    logic [s_way:0] c;
    logic [s_way-1:0] q;
    access = p;
    c = {1'b0, w} + (s_way+1)'(np);
    for (int i = 0; i < s_way; i++) begin
      q = c[s_way:1] - s_way'(!c[0]);
      access[q] = c[0];
      c = {1'b0, q};
    end
  endfunction
  function automatic logic [s_way-1:0] pick(input logic [num_ways-2:0] p);
    logic [s_way:0] n;
    n = '0;
    for (int i = 0; i < s_way; i++)
      n = {n[s_way-1:0], 1'b1} + (s_way+1)'(p[n[s_way-1:0]]);
    pick = s_way'(n - (s_way+1)'(np));
  endfunction
  assign busy = (state == INVAL);
  assign hit = match && !busy;
  assign victim_way = pick(plru[index]);
  always_comb begin
    match = 1'b0;
    hit_way = '0;
    for (int i = num_ways - 1; i >= 0; i--)
      if (valid[index][i] && tags[index][i] == lookup_tag) begin
        match = 1'b1;
        hit_way = s_way'(i);
      end
  end
  always_ff @(posedge clk)
    if (fill && !busy) tags[index][fill_way] <= fill_tag;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ctr <= '0;
      for (int s = 0; s < num_set; s++) begin
        valid[s] <= '0;
        plru[s] <= '0;
      end
    end else if (state == INVAL) begin
      valid[ctr] <= '0;
      plru[ctr] <= '0;
      ctr <= ctr + s_index'(1);
      state <= &ctr ? IDLE : INVAL;
    end else begin
      if (inval_req) begin
        state <= INVAL;
        ctr <= '0;
      end
      if (fill) begin
        valid[index][fill_way] <= 1'b1;
        plru[index] <= access(plru[index], fill_way);
      end else if (touch && hit) plru[index] <= access(plru[index], hit_way);
    end
  end
endmodule

// File: tb/tb_icache_meta_array.sv
// tb_icache_meta_array: scoreboard bench; expected {hit,hit_way,victim_way,busy} queued at drive time, popped at sample time.
module tb_icache_meta_array;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] index = '0;
  logic [22:0] lookup_tag = '0, fill_tag = '0;
  logic hit, busy, touch = 1'b0, fill = 1'b0, inval_req = 1'b0;
  logic [1:0] hit_way, victim_way, fill_way = '0;
  typedef struct {string nm; logic [5:0] v;} exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  icache_meta_array dut (
    .clk(clk), .rst(rst), .index(index), .lookup_tag(lookup_tag), .hit(hit),
    .hit_way(hit_way), .victim_way(victim_way), .touch(touch), .fill(fill),
    .fill_way(fill_way), .fill_tag(fill_tag), .inval_req(inval_req), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [5:0] ev(logic h, logic [1:0] w, logic [1:0] v, logic b);
    return {h, w, v, b};
  endfunction
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      index = 3'(i);
      lookup_tag = '0;
      q.push_back('{$sformatf("reset set%0d", i), ev(0, 0, 0, 0)});
      #1;
      e = q.pop_front();
      tests++;
      if ({hit, hit_way, victim_way, busy} !== e.v) begin
        fails++;
        $display("FAIL %s: got %b want %b", e.nm, {hit, hit_way, victim_way, busy}, e.v);
      end
    end
  endtask
  task automatic test_fill;
    logic [1:0] vs [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
    logic [2:0] ci [4] = '{3'd3, 3'd3, 3'd3, 3'd4};
    logic [22:0] ct [4] = '{23'h12, 23'h11, 23'h13, 23'h12};
    logic [5:0] cx [4];
    cx = '{ev(1, 1, 0, 0), ev(1, 2, 0, 0), ev(1, 3, 0, 0), ev(0, 0, 0, 0)};
    for (int k = 0; k < 4; k++) begin
      tick();
      index = 3;
      lookup_tag = 23'(16 + k);
      fill = 1'b1;
      fill_way = vs[k];
      fill_tag = 23'(16 + k);
      q.push_back('{$sformatf("fill%0d victim", k), ev(0, 0, vs[k], 0)});
      #1;
      e = q.pop_front();
      tests++;
      if ({hit, hit_way, victim_way, busy} !== e.v) begin
        fails++;
        $display("FAIL %s: got %b want %b", e.nm, {hit, hit_way, victim_way, busy}, e.v);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      fill = 1'b0;
      index = ci[k];
      lookup_tag = ct[k];
      q.push_back('{$sformatf("post-fill lookup%0d", k), cx[k]});
      #1;
      e = q.pop_front();
      tests++;
      if ({hit, hit_way, victim_way, busy} !== e.v) begin
        fails++;
        $display("FAIL %s: got %b want %b", e.nm, {hit, hit_way, victim_way, busy}, e.v);
      end
    end
  endtask
  task automatic test_touch;
    logic [22:0] tg [4] = '{23'h99, 23'h99, 23'h10, 23'h10};
    logic tc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [5:0] x [4];
    x = '{ev(0, 0, 0, 0), ev(0, 0, 0, 0), ev(1, 0, 0, 0), ev(1, 0, 2, 0)};
    for (int k = 0; k < 4; k++) begin
      tick();
      index = 3;
      lookup_tag = tg[k];
      touch = tc[k];
      q.push_back('{$sformatf("touch step%0d", k), x[k]});
      #1;
      e = q.pop_front();
      tests++;
      if ({hit, hit_way, victim_way, busy} !== e.v) begin
        fails++;
        $display("FAIL %s: got %b want %b", e.nm, {hit, hit_way, victim_way, busy}, e.v);
      end
    end
    touch = 1'b0;
  endtask
  task automatic test_fill_touch;
    logic [22:0] tg [6] = '{23'h10, 23'h77, 23'h12, 23'h10, 23'h88, 23'h13};
    logic f [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] fw [6] = '{2'd1, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
    logic [22:0] ft [6] = '{23'h77, 23'h0, 23'h0, 23'h88, 23'h0, 23'h0};
    logic [5:0] x [6];
    x = '{ev(1, 0, 2, 0), ev(1, 1, 2, 0), ev(0, 0, 2, 0), ev(1, 0, 2, 0), ev(1, 3, 0, 0), ev(0, 0, 0, 0)};
    for (int k = 0; k < 6; k++) begin
      tick();
      index = 3;
      lookup_tag = tg[k];
      touch = f[k];
      fill = f[k];
      fill_way = fw[k];
      fill_tag = ft[k];
      q.push_back('{$sformatf("fill+touch step%0d", k), x[k]});
      #1;
      e = q.pop_front();
      tests++;
      if ({hit, hit_way, victim_way, busy} !== e.v) begin
        fails++;
        $display("FAIL %s: got %b want %b", e.nm, {hit, hit_way, victim_way, busy}, e.v);
      end
    end
    touch = 1'b0;
    fill = 1'b0;
  endtask
  task automatic test_inval;
    tick();
    index = 3;
    lookup_tag = 23'h10;
    inval_req = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      inval_req = 1'b0;
      fill = (j == 2);
      fill_way = 0;
      fill_tag = 23'h55;
      q.push_back('{$sformatf("inval busy cycle%0d", j), ev(0, 0, 0, 1)});
      #1;
      e = q.pop_front();
      tests++;
      if ({hit, hit_way, victim_way, busy} !== e.v) begin
        fails++;
        $display("FAIL %s: got %b want %b", e.nm, {hit, hit_way, victim_way, busy}, e.v);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      fill = (i == 8);
      fill_way = 2;
      fill_tag = 23'h66;
      index = i < 8 ? 3'(i) : 3'd5;
      lookup_tag = i == 3 ? 23'h88 : i < 9 ? 23'h55 : 23'h66;
      q.push_back('{$sformatf("post-inval lookup%0d", i), i == 9 ? ev(1, 2, 0, 0) : ev(0, 0, 0, 0)});
      #1;
      e = q.pop_front();
      tests++;
      if ({hit, hit_way, victim_way, busy} !== e.v) begin
        fails++;
        $display("FAIL %s: got %b want %b", e.nm, {hit, hit_way, victim_way, busy}, e.v);
      end
    end
    fill = 1'b0;
  endtask
  task automatic test_reset_mid_inval;
    tick();
    inval_req = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      inval_req = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      index = 3'(i);
      lookup_tag = i == 5 ? 23'h66 : 23'h88;
      q.push_back('{$sformatf("after mid-inval reset set%0d", i), ev(0, 0, 0, 0)});
      #1;
      e = q.pop_front();
      tests++;
      if ({hit, hit_way, victim_way, busy} !== e.v) begin
        fails++;
        $display("FAIL %s: got %b want %b", e.nm, {hit, hit_way, victim_way, busy}, e.v);
      end
    end
    tick();
    index = 0;
    lookup_tag = '0;
    inval_req = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      inval_req = 1'b0;
      q.push_back('{$sformatf("re-inval cycle%0d", j), ev(0, 0, 0, j <= 8)});
      #1;
      e = q.pop_front();
      tests++;
      if ({hit, hit_way, victim_way, busy} !== e.v) begin
        fails++;
        $display("FAIL %s: got %b want %b", e.nm, {hit, hit_way, victim_way, busy}, e.v);
      end
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_touch();
    test_fill_touch();
    test_inval();
    test_reset_mid_inval();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
